// File: rtl/otg_hpi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : otg_hpi_bus_master
// Description : Avalon-MM slave that turns each Avalon access into one timed
//               HPI read or write cycle on the CY7C67200 EZ-OTG host port.
//               Setup, strobe, hold and recovery lengths come from parameters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   address[1:0]   in   HPI register select (0 data, 1 mailbox, 2 addr, 3 status)
//   chipselect     in   Avalon slave select
//   read_n         in   Avalon read, active low
//   write_n        in   Avalon write, active low (wins if both are low)
//   writedata[31:0] in  bits [15:0] go to the HPI bus
//   readdata[31:0] out  captured HPI word (bit 16 = interrupt when enabled)
//   waitrequest    out  Avalon stall, low only in the DONE cycle
//   otg_addr[1:0]  out  HPI address pins
//   otg_cs_n       out  HPI chip select, active low
//   otg_rd_n       out  HPI read strobe, active low
//   otg_wr_n       out  HPI write strobe, active low
//   otg_data_out[15:0] out  write data toward the top-level tristate
//   otg_data_oe    out  1 = FPGA drives the HPI data bus
//   otg_data_in[15:0]  in   HPI data bus value from the tristate
//   otg_int        in   HPI interrupt
//   irq            out  interrupt to the Avalon fabric
// Optional feature macro: OTG_HPI_IRQ_SYNC_EN
//   defined   : otg_int is synchronized, drives irq and readdata[16]
//   undefined : otg_int unused, irq = 0, readdata[31:16] = 0
// ============================================================================
module otg_hpi_bus_master #(
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 4,
    parameter int HOLD_CYCLES     = 2,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    input  logic        otg_int,
    output logic        irq
);

    localparam int c_MAX_SS  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int c_MAX_HR  = (HOLD_CYCLES > RECOVERY_CYCLES) ? HOLD_CYCLES : RECOVERY_CYCLES;
    localparam int c_MAX_CYC = (c_MAX_SS > c_MAX_HR) ? c_MAX_SS : c_MAX_HR;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;

    // Counter reload values: the counter runs N-1 .. 0 for an N-clock phase.
    localparam logic [c_CNT_W-1:0] c_SETUP_LD   = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD  = c_CNT_W'(STROBE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD    = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RECOVER_LD = c_CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_cnt_zero;
    logic                 w_req;
    logic                 w_req_wr;
    logic                 w_dir_nxt;
    logic                 w_busy_nxt;
    logic                 r_is_write;

    logic [31:0]          r_readdata;
    logic                 r_waitrequest;
    logic [1:0]           r_addr;
    logic                 r_cs_n;
    logic                 r_rd_n;
    logic                 r_wr_n;
    logic [15:0]          r_data_out;
    logic                 r_oe;

    assign w_req      = chipselect && (!read_n || !write_n);
    assign w_req_wr   = !write_n;   // a simultaneous read+write is taken as a write
    assign w_cnt_zero = (r_cnt == '0);

    // Direction for the upcoming cycle; only IDLE can change it.
    assign w_dir_nxt  = (r_state == S_IDLE) ? w_req_wr : r_is_write;
    assign w_busy_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                        (w_state_nxt == S_HOLD);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = c_STROBE_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_HOLD_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_RECOVER;
                w_cnt_nxt   = c_RECOVER_LD;
            end
            S_RECOVER: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef OTG_HPI_IRQ_SYNC_EN
    logic r_int_s1;
    logic r_int_s2;
    logic r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_int_s1 <= 1'b0;
            r_int_s2 <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_int_s1 <= otg_int;
            r_int_s2 <= r_int_s1;
            r_irq    <= r_int_s2;
        end
    end

    assign irq = r_irq;
    logic [15:0] w_status_hi;
    assign w_status_hi = {15'b0, r_int_s2};
    logic [15:0] w_unused_wd;
    assign w_unused_wd = writedata[31:16];
`else
    assign irq = 1'b0;
    logic [15:0] w_status_hi;
    assign w_status_hi = 16'b0;
    logic w_unused_in;
    assign w_unused_in = ^{otg_int, writedata[31:16]};
`endif

    // Bus pins are registered from the next state so they change cleanly
    // on clock edges; reset forces them inactive asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_write    <= 1'b0;
            r_addr        <= 2'b0;
            r_data_out    <= 16'b0;
            r_readdata    <= 32'b0;
            r_waitrequest <= 1'b1;
            r_cs_n        <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_oe          <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_req) begin
                r_is_write <= w_req_wr;
                r_addr     <= address;
                r_data_out <= writedata[15:0];
            end
            // Sample the bus on the edge that ends the last strobe clock.
            if ((r_state == S_STROBE) && w_cnt_zero && !r_is_write) begin
                r_readdata <= {w_status_hi, otg_data_in};
            end
            r_waitrequest <= (w_state_nxt != S_DONE);
            r_cs_n        <= !w_busy_nxt;
            r_rd_n        <= !((w_state_nxt == S_STROBE) && !w_dir_nxt);
            r_wr_n        <= !((w_state_nxt == S_STROBE) && w_dir_nxt);
            r_oe          <= w_busy_nxt && w_dir_nxt;
        end
    end

    assign readdata     = r_readdata;
    assign waitrequest  = r_waitrequest;
    assign otg_addr     = r_addr;
    assign otg_cs_n     = r_cs_n;
    assign otg_rd_n     = r_rd_n;
    assign otg_wr_n     = r_wr_n;
    assign otg_data_out = r_data_out;
    assign otg_data_oe  = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_otg_hpi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_otg_hpi_bus_master
// Description : Directed self-checking bench for otg_hpi_bus_master with the
//               default timing parameters (2/4/2/2). Cycle k is the clock
//               period following the k-th rising edge after a request is
//               presented; outputs are sampled 1 ns after each rising edge.
//               Honors OTG_HPI_IRQ_SYNC_EN for the interrupt checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otg_hpi_bus_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_addr;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_int;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    otg_hpi_bus_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .read_n       (read_n),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .otg_addr     (otg_addr),
        .otg_cs_n     (otg_cs_n),
        .otg_rd_n     (otg_rd_n),
        .otg_wr_n     (otg_wr_n),
        .otg_data_out (otg_data_out),
        .otg_data_oe  (otg_data_oe),
        .otg_data_in  (otg_data_in),
        .otg_int      (otg_int),
        .irq          (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fall1;
        int   fall2;
        int   hi_cnt;
        int   wait_k;
        logic prev_cs;

        reset_n     = 1'b0;
        address     = 2'd0;
        writedata   = 32'h0;
        otg_data_in = 16'h0;
        otg_int     = 1'b0;
        bus_idle();

        // ---- Reset state ----
        step(); step(); step();
        chk("rst_cs_n", otg_cs_n, 1);
        chk("rst_rd_n", otg_rd_n, 1);
        chk("rst_wr_n", otg_wr_n, 1);
        chk("rst_oe", otg_data_oe, 0);
        chk("rst_wait", waitrequest, 1);
        chk("rst_rdata", readdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_addr", otg_addr, 0);
        chk("rst_dout", otg_data_out, 0);
        reset_n = 1'b1;
        step(); step();

        // ---- Write: address 2, data ABCD1234 ----
        address = 2'd2; writedata = 32'hABCD1234; chipselect = 1'b1; write_n = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("wr_cs_n[%0d]", k), otg_cs_n, (k <= 8) ? 0 : 1);
            chk($sformatf("wr_wr_n[%0d]", k), otg_wr_n, (k >= 3 && k <= 6) ? 0 : 1);
            chk($sformatf("wr_rd_n[%0d]", k), otg_rd_n, 1);
            chk($sformatf("wr_oe[%0d]", k), otg_data_oe, (k <= 8) ? 1 : 0);
            chk($sformatf("wr_wait[%0d]", k), waitrequest, (k == 9) ? 0 : 1);
            if (k <= 8) begin
                chk($sformatf("wr_addr[%0d]", k), otg_addr, 2);
                chk($sformatf("wr_dout[%0d]", k), otg_data_out, 32'h1234);
            end
        end
        bus_idle();
        chk("wr_rdata_untouched", readdata, 0);
        for (int k = 10; k <= 12; k++) begin
            step();
            chk($sformatf("wr_rec_wait[%0d]", k), waitrequest, 1);
            chk($sformatf("wr_rec_cs_n[%0d]", k), otg_cs_n, 1);
        end

        // ---- Read: address 0, bus holds 5A5A only during the strobe ----
        otg_data_in = 16'h1111;
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("rd_cs_n[%0d]", k), otg_cs_n, (k <= 8) ? 0 : 1);
            chk($sformatf("rd_rd_n[%0d]", k), otg_rd_n, (k >= 3 && k <= 6) ? 0 : 1);
            chk($sformatf("rd_wr_n[%0d]", k), otg_wr_n, 1);
            chk($sformatf("rd_oe[%0d]", k), otg_data_oe, 0);
            chk($sformatf("rd_wait[%0d]", k), waitrequest, (k == 9) ? 0 : 1);
            if (k == 9) chk("rd_rdata", readdata, 32'h00005A5A);
            if (k == 2) otg_data_in = 16'h5A5A;
            if (k == 7) otg_data_in = 16'h1111;
        end
        bus_idle();
        step(); step(); step();

        // ---- Both read_n and write_n low: executed as a write ----
        address = 2'd3; writedata = 32'hFFFF4321; chipselect = 1'b1;
        read_n = 1'b0; write_n = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("ill_rd_n[%0d]", k), otg_rd_n, 1);
            chk($sformatf("ill_wr_n[%0d]", k), otg_wr_n, (k >= 3 && k <= 6) ? 0 : 1);
            chk($sformatf("ill_oe[%0d]", k), otg_data_oe, (k <= 8) ? 1 : 0);
            if (k == 4) chk("ill_dout", otg_data_out, 32'h4321);
            if (k == 4) chk("ill_addr", otg_addr, 3);
        end
        bus_idle();
        chk("ill_rdata_kept", readdata, 32'h00005A5A);
        step(); step(); step();

        // ---- Back-to-back: request held continuously ----
        address = 2'd1; writedata = 32'h0000BEEF; chipselect = 1'b1; write_n = 1'b0;
        fall1 = -1; fall2 = -1; hi_cnt = 0; prev_cs = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (prev_cs && !otg_cs_n) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (fall1 >= 0 && fall2 < 0 && otg_cs_n) hi_cnt++;
            prev_cs = otg_cs_n;
            if (k == 9) chk("b2b_first_done", waitrequest, 0);
            if (fall2 >= 0) break;
        end
        chk("b2b_fall1", fall1, 1);
        chk("b2b_fall2", fall2, 13);
        chk("b2b_cs_high", hi_cnt, 4);
        wait_k = 0;
        while (waitrequest && wait_k < 20) begin
            step();
            wait_k++;
        end
        chk("b2b_second_latency", wait_k, 8);
        bus_idle();
        step(); step(); step();

        // ---- Reset asserted mid-strobe of a write ----
        address = 2'd2; writedata = 32'h00005555; chipselect = 1'b1; write_n = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        chk("mid_pre_wr_n", otg_wr_n, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_n", otg_wr_n, 1);
        chk("mid_rst_cs_n", otg_cs_n, 1);
        chk("mid_rst_oe", otg_data_oe, 0);
        chk("mid_rst_wait", waitrequest, 1);
        bus_idle();
        step(); step();
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("post_rst_wait[%0d]", k), waitrequest, 1);
            chk($sformatf("post_rst_cs_n[%0d]", k), otg_cs_n, 1);
        end

        // ---- chipselect dropped mid-transaction: read still completes ----
        otg_data_in = 16'h7E57;
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("csd_wait[%0d]", k), waitrequest, (k == 9) ? 0 : 1);
            if (k == 6) chk("csd_rd_n", otg_rd_n, 0);
            if (k == 9) chk("csd_rdata", readdata, 32'h00007E57);
            if (k == 2) bus_idle();
        end
        step(); step();

        // ---- Interrupt path ----
        otg_int = 1'b1;
        step(); step();
`ifdef OTG_HPI_IRQ_SYNC_EN
        chk("irq_c2", irq, 0);
        step();
        chk("irq_c3", irq, 1);
`else
        chk("irq_c2", irq, 0);
        step();
        chk("irq_c3", irq, 0);
`endif
        otg_data_in = 16'hC0DE;
        address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 9) begin
`ifdef OTG_HPI_IRQ_SYNC_EN
                chk("irq_rdata", readdata, 32'h0001C0DE);
`else
                chk("irq_rdata", readdata, 32'h0000C0DE);
                chk("irq_tied", irq, 0);
`endif
            end
        end
        bus_idle();
        otg_int = 1'b0;
        step(); step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
